// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: imem handshake, execute redirects, decode delivery and fault report.
// master = fetch_sequencer, slave = memory/execute/decode environment.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, fault, fault_cause, fault_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_target, stall
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, fault, fault_cause, fault_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_target, stall
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and fetch sequencer: one outstanding imem request, one instruction held for decode,
// redirects absorbed mid-fetch via a kill flag, sticky misalign/timeout fault.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15,
  parameter int          WAIT_W   = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DELIVER, FAULT} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       ktgt;
  logic              kill;
  logic [WAIT_W-1:0] wcnt;
  logic              redir_bad;
  logic              redir_ok;

  assign redir_bad     = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
  assign redir_ok      = bus.redirect_valid && (bus.redirect_target[1:0] == 2'b00);
  assign bus.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      ktgt            <= '0;
      kill            <= 1'b0;
      wcnt            <= '0;
      bus.imem_req    <= 1'b0;
      bus.inst_valid  <= 1'b0;
      bus.inst_out    <= '0;
      bus.inst_pc     <= '0;
      bus.fault       <= 1'b0;
      bus.fault_cause <= 2'b00;
      bus.fault_pc    <= '0;
    end else if (state != FAULT && redir_bad) begin
      // Misaligned target wins over everything, including an ack in the same cycle.
      state           <= FAULT;
      bus.fault       <= 1'b1;
      bus.fault_cause <= 2'b01;
      bus.fault_pc    <= bus.redirect_target;
      bus.imem_req    <= 1'b0;
      bus.inst_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state        <= REQ;
          bus.imem_req <= 1'b1;
          if (redir_ok) pc <= bus.redirect_target;
        end
        REQ: begin
          if (bus.imem_ack) begin
            wcnt <= '0;
            if (redir_ok) begin
              pc   <= bus.redirect_target;
              kill <= 1'b0;
            end else if (kill) begin
              pc   <= ktgt;
              kill <= 1'b0;
            end else begin
              bus.inst_out   <= bus.imem_rdata;
              bus.inst_pc    <= pc;
              bus.inst_valid <= 1'b1;
              bus.imem_req   <= 1'b0;
              pc             <= pc + 32'd4;
              state          <= DELIVER;
            end
          end else if (wcnt == WAIT_LAST) begin
            state           <= FAULT;
            bus.fault       <= 1'b1;
            bus.fault_cause <= 2'b10;
            bus.fault_pc    <= pc;
            bus.imem_req    <= 1'b0;
          end else begin
            // Address must stay put until the ack; remember where to go afterwards.
            wcnt <= wcnt + 1'b1;
            if (redir_ok) begin
              kill <= 1'b1;
              ktgt <= bus.redirect_target;
            end
          end
        end
        DELIVER: begin
          if (redir_ok || !bus.stall) begin
            bus.inst_valid <= 1'b0;
            bus.imem_req   <= 1'b1;
            state          <= REQ;
            if (redir_ok) pc <= bus.redirect_target;
          end
        end
        FAULT: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Transaction-level check of fetch_sequencer: next-pc rule (pc+4 or redirect target),
// memory contents as a pure function of address, directed plan steps then random transactions.
module tb_fetch_sequencer;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_pc;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch transaction. rmode: 0 none, 1 redirect during wait, 2 two redirects during wait
  // (latest wins), 3 redirect on the ack cycle, 4 redirect while holding in deliver.
  task automatic fetch(input int w, input int s, input int rmode,
                       input logic [31:0] t1, input logic [31:0] t2);
    logic [31:0] data, base, tgt;
    logic        done;
    done = 1'b0;
    chk("req_high", 32'(bus.imem_req), 32'd1);
    chk("req_addr", bus.imem_addr, exp_pc);
    for (int i = 0; i < w; i++) begin
      bus.imem_ack = 1'b0;
      bus.redirect_valid  = ((rmode == 1 || rmode == 2) && i == 0) || (rmode == 2 && i == w - 1);
      bus.redirect_target = (rmode == 2 && i == w - 1) ? t2 : t1;
      tick();
      bus.redirect_valid = 1'b0;
      chk("addr_stable", bus.imem_addr, exp_pc);
      chk("no_inst_wait", 32'(bus.inst_valid), 32'd0);
      chk("no_fault_wait", 32'(bus.fault), 32'd0);
    end
    data = mem_of(exp_pc);
    bus.imem_ack        = 1'b1;
    bus.imem_rdata      = data;
    bus.redirect_valid  = (rmode == 3);
    bus.redirect_target = t1;
    tick();
    bus.imem_ack       = 1'b0;
    bus.redirect_valid = 1'b0;
    if (rmode >= 1 && rmode <= 3) begin
      tgt = (rmode == 2) ? t2 : t1;
      chk("killed_no_inst", 32'(bus.inst_valid), 32'd0);
      chk("killed_req", 32'(bus.imem_req), 32'd1);
      chk("killed_addr", bus.imem_addr, tgt);
      exp_pc = tgt;
    end else begin
      chk("inst_valid", 32'(bus.inst_valid), 32'd1);
      chk("inst_pc", bus.inst_pc, exp_pc);
      chk("inst_out", bus.inst_out, data);
      chk("req_low_deliver", 32'(bus.imem_req), 32'd0);
      base   = exp_pc;
      exp_pc = exp_pc + 32'd4;
      for (int i = 0; i < s && !done; i++) begin
        bus.stall           = 1'b1;
        bus.redirect_valid  = (rmode == 4 && i == s - 1);
        bus.redirect_target = t1;
        tick();
        bus.redirect_valid = 1'b0;
        if (rmode == 4 && i == s - 1) begin
          chk("redir_deliver_drop", 32'(bus.inst_valid), 32'd0);
          chk("redir_deliver_req", 32'(bus.imem_req), 32'd1);
          chk("redir_deliver_addr", bus.imem_addr, t1);
          exp_pc = t1;
          done   = 1'b1;
        end else begin
          chk("hold_valid", 32'(bus.inst_valid), 32'd1);
          chk("hold_out", bus.inst_out, data);
          chk("hold_pc", bus.inst_pc, base);
          chk("hold_req_low", 32'(bus.imem_req), 32'd0);
        end
      end
      bus.stall = 1'b0;
      if (!done) begin
        bus.redirect_valid  = (rmode == 4);
        bus.redirect_target = t1;
        tick();
        bus.redirect_valid = 1'b0;
        if (rmode == 4) exp_pc = t1;
        chk("release_valid", 32'(bus.inst_valid), 32'd0);
        chk("release_req", 32'(bus.imem_req), 32'd1);
        chk("release_addr", bus.imem_addr, exp_pc);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_cause", 32'(bus.fault_cause), 32'd0);
    chk("rst_fault_pc", bus.fault_pc, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    // A stale ack in the first post-reset cycle must be dropped.
    rst = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    chk("idle_ack_ignored", 32'(bus.inst_valid), 32'd0);
    exp_pc = 32'h0;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom();
    t = t & 32'h0000_FFFC;
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFFC;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, s, m;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    bus.stall = 1'b0;
    rst = 1'b1;

    do_reset();
    fetch(1, 0, 0, 0, 0);
    fetch(1, 0, 0, 0, 0);
    fetch(1, 0, 0, 0, 0);
    chk("seq_next_addr", bus.imem_addr, 32'hC);

    do_reset();
    chk("stall_word", mem_of(32'h0), 32'h0050_0093);
    fetch(1, 3, 0, 0, 0);
    chk("after_stall_addr", bus.imem_addr, 32'h4);
    fetch(1, 0, 0, 0, 0);
    fetch(2, 0, 1, 32'h100, 0);
    fetch(1, 0, 0, 0, 0);
    fetch(0, 0, 3, 32'hC, 0);
    fetch(1, 0, 3, 32'h40, 0);
    fetch(1, 2, 4, 32'h80, 0);
    fetch(1, 0, 0, 0, 0);
    fetch(3, 0, 2, 32'h200, 32'h300);
    fetch(MAX_WAIT - 1, 1, 0, 0, 0);
    fetch(1, 0, 3, 32'hFFFF_FFFC, 0);
    fetch(1, 0, 0, 0, 0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    fetch(0, 0, 0, 0, 0);

    for (int k = 0; k < 150; k++) begin
      w = $urandom_range(0, 5);
      s = $urandom_range(0, 3);
      m = $urandom_range(0, 4);
      if (m == 2 && w < 2) m = 1;
      if (m == 1 && w < 1) m = 3;
      fetch(w, s, m, rand_tgt(), rand_tgt());
    end

    // Reset while a request is outstanding; the following ack must be ignored.
    rst = 1'b1;
    tick();
    chk("midrst_req", 32'(bus.imem_req), 32'd0);
    rst = 1'b0;
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk("midrst_no_inst", 32'(bus.inst_valid), 32'd0);
    chk("midrst_req_on", 32'(bus.imem_req), 32'd1);
    exp_pc = 32'h0;
    fetch(1, 0, 0, 0, 0);

    // Misaligned redirect, then everything else ignored until reset.
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h102;
    bus.imem_ack = 1'b1;
    tick();
    chk("mis_fault", 32'(bus.fault), 32'd1);
    chk("mis_cause", 32'(bus.fault_cause), 32'd1);
    chk("mis_pc", bus.fault_pc, 32'h102);
    chk("mis_req", 32'(bus.imem_req), 32'd0);
    chk("mis_valid", 32'(bus.inst_valid), 32'd0);
    bus.redirect_target = 32'h40;
    for (int i = 0; i < 3; i++) tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ack = 1'b0;
    chk("mis_sticky_cause", 32'(bus.fault_cause), 32'd1);
    chk("mis_sticky_pc", bus.fault_pc, 32'h102);
    chk("mis_sticky_req", 32'(bus.imem_req), 32'd0);
    do_reset();

    // Timeout at 0x20: MAX_WAIT-1 silent cycles are fine, the next one faults.
    fetch(0, 0, 3, 32'h20, 0);
    for (int i = 0; i < MAX_WAIT - 1; i++) tick();
    chk("to_not_yet", 32'(bus.fault), 32'd0);
    tick();
    chk("to_fault", 32'(bus.fault), 32'd1);
    chk("to_cause", 32'(bus.fault_cause), 32'd2);
    chk("to_pc", bus.fault_pc, 32'h20);
    chk("to_req", 32'(bus.imem_req), 32'd0);
    do_reset();
    chk("post_fault_addr", bus.imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-side controller that owns the program counter and sequences instruction fetches over a req/ack handshake to instruction memory. It delivers one instruction at a time to decode, holding it while decode stalls. It absorbs redirects (taken branch, jal, jalr) from execute, including redirects that arrive while a fetch is outstanding. It detects misaligned targets and memory timeouts and reports them as a sticky fault.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
MAX_WAIT, 15, cycles in REQ without imem_ack before a timeout fault.
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; equals current pc.
imem_ack  in  1  memory response; imem_rdata is valid in the same cycle.
imem_rdata  in  32  fetched instruction word.
redirect_valid  in  1  single-cycle redirect pulse from execute.
redirect_target  in  32  absolute next-PC for the redirect (branch/jal sum or jalr result).
stall  in  1  decode cannot accept the delivered instruction this cycle.
inst_valid  out  1  inst_out and inst_pc are valid.
inst_out  out  32  delivered instruction.
inst_pc  out  32  address of inst_out.
fault  out  1  sticky fault indicator.
fault_cause  out  2  2'b00 none, 2'b01 misaligned target, 2'b10 fetch timeout.
fault_pc  out  32  offending target or address.

Behaviour:
- States: IDLE, REQ, DELIVER, FAULT. All outputs are registered except imem_addr, which is driven directly from pc.
- Reset (any state, any cycle, including mid-fetch): state=IDLE; pc=RESET_PC; kill=0; wait counter=0; imem_req=0; inst_valid=0; inst_out=0; inst_pc=0; fault=0; fault_cause=0; fault_pc=0.
- IDLE -> REQ unconditionally on the next cycle. imem_ack is ignored in IDLE, so a stale ack after reset is dropped.
- REQ:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - Wait counter increments each cycle without ack.
  - On ack with kill=0: inst_out<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, go to DELIVER.
  - On ack with kill=1: discard data, kill<=0, pc<=saved target, stay in REQ with the counter cleared. Address changes only after the ack.
- DELIVER:
  - imem_req=0; inst_valid stays 1 while stall=1.
  - When stall=0: inst_valid<=0, go to REQ. Steady-state throughput is 1 instruction per 2 cycles.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Redirect (redirect_valid=1) takes priority over stall and over normal sequencing:
  - Target check first: if redirect_target[1:0]!=0, go to FAULT with fault_cause=01 and fault_pc=target. Ignore any concurrent ack.
  - IDLE: pc<=target.
  - REQ without ack: kill<=1, store target; the fetch completes and is then discarded.
  - REQ with ack in the same cycle: discard the data, pc<=target, stay in REQ.
  - DELIVER: inst_valid<=0, pc<=target, go to REQ.
  - Multiple redirects while kill is pending: the latest target wins.
- Timeout: in REQ, if the counter reaches MAX_WAIT with no ack, go to FAULT with fault_cause=10 and fault_pc=pc.
- FAULT: fault=1; imem_req=0; inst_valid=0. Redirects, acks and stall are ignored. Only rst exits FAULT.
- When the stored target is committed to pc, the inst_pc of the next delivered instruction equals that target.

Test Plan:
- Reset and sequence: rst high 2 cycles, then ack after 1 wait cycle each fetch, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches each; inst_valid pulses one cycle per instruction.
- Stall hold: deliver 0x00500093 at pc 0x0, hold stall=1 for 3 cycles -> inst_valid and inst_out stable for 4 cycles, imem_req=0 throughout, next fetch address is 0x4.
- Redirect during outstanding fetch: pc=0x8 in REQ, redirect to 0x100 two cycles before ack -> imem_addr stays 0x8 until ack, data discarded (no inst_valid), next request to 0x100, delivered inst_pc=0x100.
- Redirect on ack cycle and in DELIVER: redirect to 0x40 coincident with ack at 0xC -> no delivery, next fetch at 0x40. Redirect to 0x80 while stalled in DELIVER -> inst_valid drops the next cycle, fetch at 0x80.
- Faults: redirect to 0x102 -> fault=1, cause=01, fault_pc=0x102, imem_req=0, later redirects ignored. Separately, no ack for MAX_WAIT cycles at 0x20 -> cause=10, fault_pc=0x20. rst clears both.
- Wrap and mid-operation reset: redirect to 0xFFFFFFFC, deliver -> next fetch at 0x0. Assert rst while in REQ, then ack in the following cycle -> ack ignored, imem_addr=RESET_PC.
